mul_seq_param: RTL and testbench

Parametrised sequential shift-add multiplier. It is the successor of the fixed 4-bit `mul` block.
- Adds: width parameter W, runtime signed/unsigned mode, busy/done handshake, and a result that holds until the next load.
- Sits as a multicycle arithmetic unit beside the datapath. It exposes its internal ra/rb/ry registers for debug and bench visibility, as `mul` does.

---
 rtl/mul_seq_param.sv | 91 +++++++++
 tb/tb_mul_seq_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_param.sv
// mul_seq_param: W-bit sequential shift-add multiplier with signed/unsigned mode and a busy/done handshake.
// Defining MUL_EARLY_TERM_EN lets RUN stop as soon as no multiplier bits remain.
module mul_seq_param #(
  parameter int W  = 4,
  parameter int CW = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic           sgn,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] ra,
  output logic [W-1:0]   rb,
  output logic [2*W-1:0] ry,
  output logic           busy,
  output logic           done
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [2*W-1:0] ra_q, ra_d, ry_q, ry_d;
  logic [W-1:0]   rb_q, rb_d, a_mag, b_mag;
  logic [CW-1:0]  count_q, count_d;
  logic           neg_q, neg_d, sgn_q, sgn_d, load, last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      ry_q    <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      ry_q    <= ry_d;
      count_q <= count_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
    end
  end
  // Operands are multiplied as magnitudes; the sign is restored in FIX.
  always_comb begin
    load  = (state_q == IDLE || state_q == DONE) && ld;
    a_mag = (sgn && a[W-1]) ? -a : a;
    b_mag = (sgn && b[W-1]) ? -b : b;
`ifdef MUL_EARLY_TERM_EN
    last  = count_q == CW'(W-1) || (rb_q >> 1) == '0;
`else
    last  = count_q == CW'(W-1);
`endif
  end
  always_comb begin
    state_d = load                ? RUN :
              (state_q == RUN)    ? (last ? (sgn_q ? FIX : DONE) : RUN) :
              (state_q == FIX)    ? DONE :
              (state_q == DONE)   ? IDLE : state_q;
  end
  always_comb begin
    ra_d    = ra_q;
    rb_d    = rb_q;
    ry_d    = ry_q;
    count_d = count_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    if (load) begin
      ra_d    = {{W{1'b0}}, a_mag};
      rb_d    = b_mag;
      ry_d    = '0;
      count_d = '0;
      neg_d   = sgn & (a[W-1] ^ b[W-1]);
      sgn_d   = sgn;
    end else if (state_q == RUN) begin
      ry_d    = rb_q[0] ? ry_q + ra_q : ry_q;
      ra_d    = ra_q << 1;
      rb_d    = rb_q >> 1;
      count_d = count_q + CW'(1);
    end else if (state_q == FIX) begin
      ry_d    = neg_q ? -ry_q : ry_q;
    end
  end
  always_comb begin
    busy = state_q == RUN || state_q == FIX;
    done = state_q == DONE;
  end
  assign ra = ra_q;
  assign rb = rb_q;
  assign ry = ry_q;
endmodule

// File: tb/tb_mul_seq_param.sv
// tb_mul_seq_param: scoreboard bench; loads push expected product/latency, a monitor checks each done pulse.
module tb_mul_seq_param;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, ld = 1'b0, sgn = 1'b0;
  logic [W-1:0] a = '0, b = '0, rb;
  logic [2*W-1:0] ra, ry;
  logic busy, done;
  logic ld8 = 1'b0, sgn8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, rb8;
  logic [15:0] ra8, ry8;
  logic busy8, done8;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    logic [2*W-1:0] ry;
    logic [2*W-1:0] ra;
    logic [W-1:0]   rb;
    int             dcyc;
  } exp_t;
  exp_t sb[$];
  exp_t em;
  logic [2*W-1:0] held = '0;
  logic prev_done = 1'b0;

  mul_seq_param #(.W(W)) dut (
    .clk(clk), .rst(rst), .ld(ld), .sgn(sgn), .a(a), .b(b),
    .ra(ra), .rb(rb), .ry(ry), .busy(busy), .done(done)
  );
  mul_seq_param #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .ld(ld8), .sgn(sgn8), .a(a8), .b(b8),
    .ra(ra8), .rb(rb8), .ry(ry8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: integer product of the interpreted operands; iteration count from the multiplier magnitude.
  function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv, bit s, int lc);
    exp_t m;
    int x, y, ma, mb, it;
    logic [31:0] p, t;
    x  = s ? int'($signed(av)) : int'(av);
    y  = s ? int'($signed(bv)) : int'(bv);
    ma = x < 0 ? -x : x;
    mb = y < 0 ? -y : y;
`ifdef MUL_EARLY_TERM_EN
    it = 1;
    for (int k = 0; k < W; k++) if (mb[k]) it = k + 1;
`else
    it = W;
`endif
    p = x * y;
    t = ma << it;
    m.ry = p[2*W-1:0];
    m.ra = t[2*W-1:0];
    m.rb = W'(mb >> it);
    m.dcyc = lc + it + (s ? 1 : 0);
    return m;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      chk("done_one_cycle", prev_done, 0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending product (cycle %0d)", cyc);
      end else begin
        em = sb.pop_front();
        chk("ry", ry, em.ry);
        chk("ra", ra, em.ra);
        chk("rb", rb, em.rb);
        chk("latency", cyc, em.dcyc);
        held = em.ry;
      end
    end else if (!busy && !rst) begin
      chk("ry_held", ry, held);
    end
    prev_done = done;
  end

  task automatic issue(logic [W-1:0] av, logic [W-1:0] bv, bit s);
    a = av; b = bv; sgn = s; ld = 1'b1;
    sb.push_back(model(av, bv, s, cyc + 1));
    @(negedge clk);
    ld = 1'b0; a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 3 * W + 8) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done after %0d cycles want done", n);
      sb.delete();
    end
  endtask

  task automatic w8(logic [7:0] av, logic [7:0] bv, bit s, logic [15:0] exp, int lat);
    int c, n;
    a8 = av; b8 = bv; sgn8 = s; ld8 = 1'b1;
    c = cyc + 1;
    @(negedge clk);
    ld8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("w8_done", done8, 1);
    chk("w8_latency", cyc, c + lat);
    chk("w8_ry", ry8, exp);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ra", ra, 0);
    chk("rst_rb", rb, 0);
    chk("rst_ry", ry, 0);
    issue(4'b0011, 4'b1101, 0);
    chk("t1_busy", busy, 1);
    wait_done();
    chk("t1_ry", ry, 8'h27);
    issue(4'b0011, 4'b1101, 1);
    wait_done();
    chk("t2_ry", ry, 8'hF7);
    issue(4'b1000, 4'b1000, 1);
    wait_done();
    chk("t2b_ry", ry, 8'h40);
    issue(4'hF, 4'hF, 0);
    wait_done();
    chk("t3_ry", ry, 8'hE1);
    issue(4'h5, 4'h6, 0);
    @(negedge clk);
    ld = 1'b1; a = 4'h9; b = 4'h9;
    @(negedge clk);
    ld = 1'b0;
    wait_done();
    chk("ignore_ld_ry", ry, 8'h1E);
    issue(4'h7, 4'h9, 0);
    @(negedge clk);
    a = 4'hB; b = 4'h2; sgn = 1'b0; ld = 1'b1;
    wait_done();
    sb.push_back(model(4'hB, 4'h2, 0, cyc + 1));
    @(negedge clk);
    ld = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_done();
    chk("b2b_ry", ry, 8'h16);
    issue(4'h9, 4'h0, 0);
    wait_done();
    issue(4'h9, 4'h0, 1);
    wait_done();
    issue(4'h7, 4'h1, 0);
    wait_done();
    chk("t6_ry", ry, 8'h07);
    @(negedge clk);
    issue(4'h6, 4'h7, 0);
    @(negedge clk);
    sb.delete();
    held = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ra", ra, 0);
    chk("abort_rb", rb, 0);
    chk("abort_ry", ry, 0);
    repeat (6) @(negedge clk);
    repeat (150) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom));
      wait_done();
    end
    w8(8'hFF, 8'hFF, 0, 16'hFE01, 8);
    w8(8'h80, 8'h80, 1, 16'h4000, 9);
    w8(8'h05, 8'hFD, 1, 16'hFFF1, 9);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
